// File: rtl/adder_share_pkg.sv
// Shared types and constants for the shared-adder arbiter.
package adder_share_pkg;

   // Default sizing of one arbiter instance
   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned DEF_WIDTH   = 12;

   // Arbiter control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Width of a requester index; never narrower than one bit
   function automatic int unsigned id_width(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/adder_share_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping.
module adder_share_rr_pick
   import adder_share_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_valid
);

   // Scan candidates in priority order starting at ptr
   always_comb begin
      logic [ID_W-1:0] cand;
      cand         = '0;
      grant_idx    = '0;
      any_valid    = 1'b0;
      grant_onehot = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((32'(ptr) + k) % NUM_REQ);
         if (!any_valid && req_valid[cand]) begin
            any_valid = 1'b1;
            grant_idx = cand;
         end
      end
      if (any_valid) begin
         grant_onehot[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one external adder among NUM_REQ requesters with a tagged response.
module adder_share_arbiter
   import adder_share_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]         add_op_a,
   output logic [WIDTH-1:0]         add_op_b,
   input  logic [WIDTH:0]           add_sum,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [ID_W-1:0]          resp_id,
   output logic [WIDTH:0]           resp_sum,
   output logic                     busy
);

   state_t              state;
   state_t              state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     ptr_nxt;
   logic [ID_W-1:0]     id_q;
   logic [NUM_REQ-1:0]  pick_onehot;
   logic [ID_W-1:0]     pick_idx;
   logic                pick_any;
   logic                grant_ok;
   logic                grant;
   logic [WIDTH-1:0]    sel_a;
   logic [WIDTH-1:0]    sel_b;

   adder_share_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req_valid    (req_valid),
      .ptr          (rr_ptr),
      .grant_onehot (pick_onehot),
      .grant_idx    (pick_idx),
      .any_valid    (pick_any)
   );

   // A new operand pair may enter when idle or while the current result retires
   always_comb begin
      grant_ok = 1'b0;
      if (!rst) begin
         grant_ok = (state == IDLE) || ((state == RESP) && resp_ready);
      end
      grant = grant_ok && pick_any;
   end

   // Winner's operands and the pointer position just past the winner
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_onehot[i]) begin
            sel_a = req_a[i*WIDTH +: WIDTH];
            sel_b = req_b[i*WIDTH +: WIDTH];
         end
      end
      ptr_nxt = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: EXEC lasts one cycle, RESP waits for the consumer
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant) begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               state_nxt = grant ? EXEC : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output decode
   always_comb begin
      req_ready  = '0;
      busy       = 1'b0;
      resp_valid = 1'b0;
      if (grant) begin
         req_ready = pick_onehot;
      end
      busy       = (state != IDLE);
      resp_valid = (state == RESP);
   end

   // Capture the winner's operands, owner id and advance the pointer on a grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         add_op_a <= '0;
         add_op_b <= '0;
         id_q     <= '0;
         rr_ptr   <= '0;
      end else if (grant) begin
         add_op_a <= sel_a;
         add_op_b <= sel_b;
         id_q     <= pick_idx;
         rr_ptr   <= ptr_nxt;
      end
   end

   // Capture the settled adder result at the end of EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_sum <= '0;
         resp_id  <= '0;
      end else if (state == EXEC) begin
         resp_sum <= add_sum;
         resp_id  <= id_q;
      end
   end

endmodule
